trap_ctrl: RTL and testbench

Registered, parametrised trap controller replacing the purely combinational exception detector between the execute/memory stage and the CSR file. It detects synchronous exceptions (misaligned/out-of-range fetch, illegal, privileged, load/store access and misalignment), arbitrates them against a timer plus `NUM_IRQ` latched external interrupts, and presents one trap at a time to the pipeline/CSR over a req/ack handshake. It tracks handler residency until `mret`.

---
 rtl/trap_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Registered trap controller sitting between the execute/memory stage and the
// CSR file. It detects synchronous exceptions, arbitrates them against the
// machine timer and NUM_IRQ edge-latched external interrupts, and presents a
// single trap at a time over a req/ack handshake. Handler residency is tracked
// until mret.
//
// Optional feature macro: TRAP_VECTORED_EN
//   defined   : mtvec_i[1:0]==2'b01 vectors interrupts to base + 4*cause[30:0]
//   undefined : direct mode only, mtvec_i[1:0] ignored
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   inst_valid_i            sync inputs describe a real instruction
//   shouldJump_i/pcJumpDst_i taken jump and its target
//   pc_i                    current instruction PC
//   dataAddress_i           data access address
//   memInstType_i           {mem_op, store, size[1:0]}; size 00=B 01=H 10=W
//   inst_invalid_i          illegal instruction
//   priv_i/privCause_i      ecall/ebreak and its mcause
//   mtime_exc_i             timer interrupt level
//   irq_i/irq_en_i          external interrupt levels and per-line enables
//   mie_i                   global interrupt enable
//   mtvec_i                 trap vector base + mode
//   mret_i                  handler return pulse
//   trap_ack_i              trap accepted by CSR/pipeline
//   stall_o                 hold the pipeline (detect cycle and whole REQ)
//   trap_req_o              trap presented
//   trap_cause_o/info_o/epc_o/target_o   mcause, mtval, mepc, redirect PC
//   in_handler_o            handler active
//   double_fault_o          sticky: sync exception taken inside a handler
//   trap_count_o            saturating count of accepted traps
// ---------------------------------------------------------------------------

// Memory instruction descriptor: bit3 = memory op, bit2 = store, [1:0] = size.
typedef logic [3:0] mem_inst_type_t;

module trap_ctrl #(
  parameter int          NUM_IRQ               = 4,
  parameter logic [31:0] PC_VALID_RANGE_BASE   = 32'h0000_0100,
  parameter logic [31:0] PC_VALID_RANGE_LIMIT  = 32'h0000_FFFF,
  parameter logic [31:0] MEM_VALID_RANGE_BASE  = 32'h0001_0000,
  parameter logic [31:0] MEM_VALID_RANGE_LIMIT = 32'h0001_FFFF,
  parameter logic [31:0] MMIO_ADDR             = 32'h0000_0100,
  parameter int          CNT_W                 = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 inst_valid_i,
  input  logic                 shouldJump_i,
  input  logic [31:0]          pcJumpDst_i,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          dataAddress_i,
  input  mem_inst_type_t       memInstType_i,
  input  logic                 inst_invalid_i,
  input  logic                 priv_i,
  input  logic [31:0]          privCause_i,
  input  logic                 mtime_exc_i,
  input  logic [NUM_IRQ-1:0]   irq_i,
  input  logic [NUM_IRQ-1:0]   irq_en_i,
  input  logic                 mie_i,
  input  logic [31:0]          mtvec_i,
  input  logic                 mret_i,
  input  logic                 trap_ack_i,
  output logic                 stall_o,
  output logic                 trap_req_o,
  output logic [31:0]          trap_cause_o,
  output logic [31:0]          trap_info_o,
  output logic [31:0]          trap_epc_o,
  output logic [31:0]          trap_target_o,
  output logic                 in_handler_o,
  output logic                 double_fault_o,
  output logic [CNT_W-1:0]     trap_count_o
);

  localparam logic [31:0] PC_BASE   = PC_VALID_RANGE_BASE;
  localparam logic [31:0] PC_LIMIT  = PC_VALID_RANGE_LIMIT;
  localparam logic [31:0] MEM_BASE  = MEM_VALID_RANGE_BASE;
  localparam logic [31:0] MEM_LIMIT = MEM_VALID_RANGE_LIMIT;

  localparam logic [31:0] M_INSTR_MISALIGN = 32'd0;
  localparam logic [31:0] M_INSTR_AFAULT   = 32'd1;
  localparam logic [31:0] M_ILL_INSTR      = 32'd2;
  localparam logic [31:0] M_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] M_LOAD_AFAULT    = 32'd5;
  localparam logic [31:0] M_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] M_STORE_AFAULT   = 32'd7;
  localparam logic [31:0] M_TIMER_INT      = 32'h8000_0007;

  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_req;
  logic [31:0]        r_cause;
  logic [31:0]        r_info;
  logic [31:0]        r_epc;
  logic [31:0]        r_target;
  logic               r_in_handler;
  logic               r_dfault;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_irq_pend;
  logic [NUM_IRQ-1:0] r_irq_taken;   // one-hot line being presented, 0 for sync/timer

  // ---------------- synchronous exception detection ----------------
  logic        w_is_mem;
  logic        w_is_store;
  logic        w_jmp_mis;
  logic        w_pc_oob;
  logic        w_mem_oob;
  logic        w_mem_mis;
  logic        w_sync;
  logic [31:0] w_sync_cause;
  logic [31:0] w_sync_info;

  assign w_is_mem   = memInstType_i[3];
  assign w_is_store = memInstType_i[2];
  assign w_jmp_mis  = shouldJump_i && (pcJumpDst_i[1:0] != 2'b00);
  assign w_pc_oob   = (pc_i < PC_BASE) || (pc_i > PC_LIMIT);
  assign w_mem_oob  = w_is_mem && (dataAddress_i != MMIO_ADDR) &&
                      ((dataAddress_i < MEM_BASE) || (dataAddress_i > MEM_LIMIT));
  assign w_mem_mis  = w_is_mem &&
                      (((memInstType_i[1:0] == SIZE_HALF) && dataAddress_i[0]) ||
                       ((memInstType_i[1:0] == SIZE_WORD) && (dataAddress_i[1:0] != 2'b00)));

  always_comb begin
    w_sync       = 1'b0;
    w_sync_cause = '0;
    w_sync_info  = '0;
    if (inst_valid_i) begin
      if (w_jmp_mis) begin
        w_sync = 1'b1; w_sync_cause = M_INSTR_MISALIGN; w_sync_info = pcJumpDst_i;
      end else if (w_pc_oob) begin
        w_sync = 1'b1; w_sync_cause = M_INSTR_AFAULT;   w_sync_info = pc_i;
      end else if (inst_invalid_i) begin
        w_sync = 1'b1; w_sync_cause = M_ILL_INSTR;      w_sync_info = pc_i;
      end else if (priv_i) begin
        w_sync = 1'b1; w_sync_cause = privCause_i;      w_sync_info = pc_i;
      end else if (w_mem_oob) begin
        w_sync = 1'b1; w_sync_cause = w_is_store ? M_STORE_AFAULT : M_LOAD_AFAULT;
        w_sync_info = dataAddress_i;
      end else if (w_mem_mis) begin
        w_sync = 1'b1; w_sync_cause = w_is_store ? M_STORE_MISALIGN : M_LOAD_MISALIGN;
        w_sync_info = dataAddress_i;
      end
    end
  end

  // ---------------- interrupt arbitration ----------------
  logic [NUM_IRQ-1:0] w_irq_rise;
  logic [NUM_IRQ-1:0] w_irq_cand;
  logic [NUM_IRQ-1:0] w_irq_sel;
  logic [NUM_IRQ-1:0] w_irq_clr;
  logic               w_irq_any;
  logic [31:0]        w_irq_cause;

  assign w_irq_rise = irq_i & ~r_irq_prev;
  assign w_irq_cand = r_irq_pend & irq_en_i;

  // Timer beats every external line; among lines the lowest index wins.
  always_comb begin
    w_irq_any   = 1'b0;
    w_irq_cause = '0;
    w_irq_sel   = '0;
    if (mtime_exc_i) begin
      w_irq_any   = 1'b1;
      w_irq_cause = M_TIMER_INT;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (!w_irq_any && w_irq_cand[i]) begin
          w_irq_any    = 1'b1;
          w_irq_cause  = {1'b1, 31'(16 + i)};
          w_irq_sel[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- trap selection ----------------
  logic        w_take_sync;
  logic        w_take_irq;
  logic        w_detect;
  logic [31:0] w_cause;
  logic [31:0] w_info;
  logic [31:0] w_base;
  logic [31:0] w_target;

  // Sync exceptions are honoured in IDLE and in HANDLER (double fault);
  // interrupts only from IDLE, and never alongside a sync exception.
  assign w_take_sync = w_sync && ((r_state == IDLE) || (r_state == HANDLER));
  assign w_take_irq  = (r_state == IDLE) && !w_sync && mie_i && w_irq_any;
  assign w_detect    = w_take_sync || w_take_irq;
  assign w_cause     = w_take_sync ? w_sync_cause : w_irq_cause;
  assign w_info      = w_take_sync ? w_sync_info  : 32'd0;
  assign w_base      = {mtvec_i[31:2], 2'b00};
  assign w_irq_clr   = ((r_state == REQ) && trap_ack_i) ? r_irq_taken : '0;

`ifdef TRAP_VECTORED_EN
  // 4*cause[30:0] truncated to 32 bits is simply cause[29:0] shifted by two.
  assign w_target = ((mtvec_i[1:0] == 2'b01) && w_cause[31]) ?
                    (w_base + {w_cause[29:0], 2'b00}) : w_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = &{1'b0, mtvec_i[1:0]};
  assign w_target      = w_base;
`endif

  // ---------------- state and registered outputs ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_cause      <= '0;
      r_info       <= '0;
      r_epc        <= '0;
      r_target     <= '0;
      r_in_handler <= 1'b0;
      r_dfault     <= 1'b0;
      r_cnt        <= '0;
      r_irq_prev   <= '0;
      r_irq_pend   <= '0;
      r_irq_taken  <= '0;
    end else begin
      r_irq_prev <= irq_i;
      // A new edge wins over the clear of the line being acknowledged.
      r_irq_pend <= (r_irq_pend & ~w_irq_clr) | w_irq_rise;

      if (w_detect) begin
        r_cause     <= w_cause;
        r_info      <= w_info;
        r_epc       <= pc_i;
        r_target    <= w_target;
        r_irq_taken <= w_take_irq ? w_irq_sel : '0;
      end

      case (r_state)
        IDLE: begin
          if (w_detect) begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        REQ: begin
          if (trap_ack_i) begin
            r_state      <= HANDLER;
            r_req        <= 1'b0;
            r_in_handler <= 1'b1;
            r_irq_taken  <= '0;
            if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        HANDLER: begin
          // An exception raised alongside mret still takes priority.
          if (w_take_sync) begin
            r_state      <= REQ;
            r_req        <= 1'b1;
            r_in_handler <= 1'b0;
            r_dfault     <= 1'b1;
          end else if (mret_i) begin
            r_state      <= IDLE;
            r_in_handler <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall_o        = w_detect || (r_state == REQ);
  assign trap_req_o     = r_req;
  assign trap_cause_o   = r_cause;
  assign trap_info_o    = r_info;
  assign trap_epc_o     = r_epc;
  assign trap_target_o  = r_target;
  assign in_handler_o   = r_in_handler;
  assign double_fault_o = r_dfault;
  assign trap_count_o   = r_cnt;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Self-checking bench for trap_ctrl. Each feature task drives stimulus and
// checks handshake/status outputs inline; every expected trap is pushed to a
// scoreboard queue and a monitor pops and compares cause/info/epc/target when
// trap_req_o rises. Built with or without TRAP_VECTORED_EN.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

  localparam int          NIRQ    = 4;
  localparam int          CW      = 2;
  localparam logic [31:0] MTVEC_D = 32'h0000_2000;
  localparam logic [31:0] PCAUSE  = 32'h0000_000B;

  localparam logic [3:0] MT_NONE = 4'b0000;
  localparam logic [3:0] MT_LB   = 4'b1000;
  localparam logic [3:0] MT_LW   = 4'b1010;
  localparam logic [3:0] MT_SB   = 4'b1100;
  localparam logic [3:0] MT_SH   = 4'b1101;
  localparam logic [3:0] MT_SW   = 4'b1110;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            inst_valid, should_jump, inst_invalid, priv, mtime_exc, mie, mret, ack;
  logic [31:0]     jump_dst, pc, daddr, priv_cause, mtvec;
  logic [3:0]      mem_type;
  logic [NIRQ-1:0] irq, irq_en;

  logic            stall, req, in_handler, dfault;
  logic [31:0]     cause, info, epc, target;
  logic [CW-1:0]   count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] info;
    logic [31:0] epc;
    logic [31:0] target;
  } trap_t;

  trap_t sb[$];
  trap_t mon_e;
  logic  mon_prev_req = 1'b0;

  always #5 clk = ~clk;

  trap_ctrl #(
    .NUM_IRQ              (NIRQ),
    .PC_VALID_RANGE_BASE  (32'h0000_0080),
    .PC_VALID_RANGE_LIMIT (32'h0000_FFFF),
    .MEM_VALID_RANGE_BASE (32'h0000_0104),
    .MEM_VALID_RANGE_LIMIT(32'h0000_01FF),
    .MMIO_ADDR            (32'h0000_0100),
    .CNT_W                (CW)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .inst_valid_i  (inst_valid),
    .shouldJump_i  (should_jump),
    .pcJumpDst_i   (jump_dst),
    .pc_i          (pc),
    .dataAddress_i (daddr),
    .memInstType_i (mem_type),
    .inst_invalid_i(inst_invalid),
    .priv_i        (priv),
    .privCause_i   (priv_cause),
    .mtime_exc_i   (mtime_exc),
    .irq_i         (irq),
    .irq_en_i      (irq_en),
    .mie_i         (mie),
    .mtvec_i       (mtvec),
    .mret_i        (mret),
    .trap_ack_i    (ack),
    .stall_o       (stall),
    .trap_req_o    (req),
    .trap_cause_o  (cause),
    .trap_info_o   (info),
    .trap_epc_o    (epc),
    .trap_target_o (target),
    .in_handler_o  (in_handler),
    .double_fault_o(dfault),
    .trap_count_o  (count)
  );

  // Scoreboard monitor: compare the presented trap on each rising trap_req_o.
  always @(negedge clk) begin
    if (req === 1'b1 && mon_prev_req !== 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_req: got req with cause %h, expected no trap", cause);
      end else begin
        mon_e = sb.pop_front();
        if (cause !== mon_e.cause) begin
          errors++; $display("FAIL sb_cause: got %h expected %h", cause, mon_e.cause);
        end
        checks++;
        if (info !== mon_e.info) begin
          errors++; $display("FAIL sb_info: got %h expected %h", info, mon_e.info);
        end
        checks++;
        if (epc !== mon_e.epc) begin
          errors++; $display("FAIL sb_epc: got %h expected %h", epc, mon_e.epc);
        end
        checks++;
        if (target !== mon_e.target) begin
          errors++; $display("FAIL sb_target: got %h expected %h", target, mon_e.target);
        end
      end
    end
    mon_prev_req = req;
  end

  // Stimulus helpers (drive only, no checking).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    inst_valid   = 1'b0;
    should_jump  = 1'b0;
    jump_dst     = 32'h0;
    daddr        = 32'h0;
    mem_type     = MT_NONE;
    inst_invalid = 1'b0;
    priv         = 1'b0;
    priv_cause   = PCAUSE;
    mtime_exc    = 1'b0;
    mret         = 1'b0;
    ack          = 1'b0;
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] i,
                      input logic [31:0] e, input logic [31:0] t);
    trap_t x;
    x.cause = c; x.info = i; x.epc = e; x.target = t;
    sb.push_back(x);
  endtask

  // Sync-exception table: ctl = {valid, jump, invalid, priv}.
  localparam int N_T = 16;
  localparam logic [3:0]  T_CTL  [N_T] = '{4'b1010, 4'b1011, 4'b1001, 4'b1000,
                                           4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                           4'b1000, 4'b1000, 4'b1000, 4'b1100,
                                           4'b1110, 4'b1000, 4'b0010, 4'b1100};
  localparam logic [3:0]  T_MT   [N_T] = '{MT_NONE, MT_NONE, MT_LW, MT_LW,
                                           MT_SH,   MT_LW,   MT_SH, MT_SB,
                                           MT_SW,   MT_LW,   MT_LB, MT_NONE,
                                           MT_NONE, MT_NONE, MT_NONE, MT_NONE};
  localparam logic [31:0] T_PC   [N_T] = '{32'h40,  32'h210, 32'h214, 32'h218,
                                           32'h21C, 32'h220, 32'h224, 32'h228,
                                           32'h22C, 32'h230, 32'h234, 32'h238,
                                           32'h23C, 32'h10000, 32'h240, 32'h40};
  localparam logic [31:0] T_DST  [N_T] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                           32'h0, 32'h0, 32'h0, 32'h0,
                                           32'h0, 32'h0, 32'h0, 32'h300,
                                           32'h103, 32'h0, 32'h0, 32'h102};
  localparam logic [31:0] T_ADDR [N_T] = '{32'h0,   32'h0,   32'h300, 32'h300,
                                           32'h201, 32'h106, 32'h105, 32'h106,
                                           32'h100, 32'h1FC, 32'h103, 32'h0,
                                           32'h0,   32'h0,   32'h0,   32'h0};
  localparam logic        T_EXP  [N_T] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                           1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] T_CAUSE[N_T] = '{32'd1, 32'd2, PCAUSE, 32'd5,
                                           32'd7, 32'd4, 32'd6,  32'd0,
                                           32'd0, 32'd0, 32'd5,  32'd0,
                                           32'd0, 32'd1, 32'd0,  32'd0};
  localparam logic [31:0] T_INFO [N_T] = '{32'h40,  32'h210, 32'h214, 32'h300,
                                           32'h201, 32'h106, 32'h105, 32'h0,
                                           32'h0,   32'h0,   32'h103, 32'h0,
                                           32'h103, 32'h10000, 32'h0, 32'h102};

  task automatic test_reset();
    #2;
    checks++;
    if ({stall, req, in_handler, dfault} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {stall, req, in_handler, dfault});
    end
    checks++;
    if ((cause | info | epc | target) !== 32'h0) begin
      errors++; $display("FAIL reset_regs: got %h/%h/%h/%h expected all 0", cause, info, epc, target);
    end
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_instr_misalign();
    inst_valid = 1'b1; should_jump = 1'b1; jump_dst = 32'h102; pc = 32'h200;
    push(32'd0, 32'h102, 32'h200, MTVEC_D);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL jmp_stall_detect: got %b expected 1", stall); end
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL jmp_req_latency: got %b expected 0", req); end
    tick();
    drive_idle();
    #1;
    checks++;
    if (req !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL jmp_req_rise: got req=%b stall=%b expected 1/1", req, stall);
    end
    tick();
    checks++;
    if (req !== 1'b1 || info !== 32'h102) begin
      errors++; $display("FAIL jmp_hold: got req=%b info=%h expected 1/00000102", req, info);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || in_handler !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL jmp_ack: got req=%b hdl=%b stall=%b expected 0/1/0", req, in_handler, stall);
    end
    checks++;
    if (count !== 2'd1) begin errors++; $display("FAIL jmp_count: got %0d expected 1", count); end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    #1;
    checks++;
    if (in_handler !== 1'b0) begin errors++; $display("FAIL jmp_mret: got %b expected 0", in_handler); end
  endtask

  task automatic test_sync_table();
    for (int i = 0; i < N_T; i++) begin
      inst_valid   = T_CTL[i][3];
      should_jump  = T_CTL[i][2];
      inst_invalid = T_CTL[i][1];
      priv         = T_CTL[i][0];
      jump_dst     = T_DST[i];
      pc           = T_PC[i];
      daddr        = T_ADDR[i];
      mem_type     = T_MT[i];
      if (T_EXP[i]) push(T_CAUSE[i], T_INFO[i], T_PC[i], MTVEC_D);
      #1;
      checks++;
      if (stall !== T_EXP[i]) begin
        errors++; $display("FAIL sync_stall[%0d]: got %b expected %b", i, stall, T_EXP[i]);
      end
      tick();
      drive_idle();
      #1;
      checks++;
      if (req !== T_EXP[i]) begin
        errors++; $display("FAIL sync_req[%0d]: got %b expected %b", i, req, T_EXP[i]);
      end
      if (T_EXP[i]) begin
        ack = 1'b1;
        tick();
        ack = 1'b0;
        mret = 1'b1;
        tick();
        mret = 1'b0;
      end
    end
  endtask

  task automatic test_irq();
    irq_en = 4'b0110;
    mie    = 1'b0;
    pc     = 32'h300;
    irq = 4'b0100; tick();
    irq = 4'b0010; tick();
    irq = 4'b1000; tick();
    irq = 4'b0000;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL irq_mie_gate: got %b expected 0", stall); end
    tick();
    mie = 1'b1;
    push(32'h8000_0011, 32'h0, 32'h300, MTVEC_D);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL irq1_detect: got %b expected 1", stall); end
    tick();
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL irq1_req: got %b expected 1", req); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    mtime_exc = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL irq_in_handler: got stall %b expected 0", stall); end
    mtime_exc = 1'b0;
    mret = 1'b1;
    push(32'h8000_0012, 32'h0, 32'h300, MTVEC_D);
    tick();
    mret = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL irq2_detect: got %b expected 1", stall); end
    tick();
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL irq2_req: got %b expected 1", req); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL irq_cleared: got stall %b expected 0", stall); end
    mie = 1'b0;
  endtask

  task automatic test_double_fault_reset();
    inst_valid = 1'b1; inst_invalid = 1'b1; pc = 32'h240;
    push(32'd2, 32'h240, 32'h240, MTVEC_D);
    tick();
    drive_idle();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if (in_handler !== 1'b1 || dfault !== 1'b0) begin
      errors++; $display("FAIL df_pre: got hdl=%b df=%b expected 1/0", in_handler, dfault);
    end
    inst_valid = 1'b1; inst_invalid = 1'b1; pc = 32'h244; mret = 1'b1;
    push(32'd2, 32'h244, 32'h244, MTVEC_D);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL df_stall: got %b expected 1", stall); end
    tick();
    drive_idle();
    #1;
    checks++;
    if (req !== 1'b1 || dfault !== 1'b1 || in_handler !== 1'b0) begin
      errors++; $display("FAIL df_state: got req=%b df=%b hdl=%b expected 1/1/0", req, dfault, in_handler);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, req, in_handler, dfault} !== 4'b0 || count !== '0) begin
      errors++; $display("FAIL rst_mid_req_flags: got %b cnt=%0d expected 0000 cnt=0",
                         {stall, req, in_handler, dfault}, count);
    end
    checks++;
    if ((cause | info | epc | target) !== 32'h0) begin
      errors++; $display("FAIL rst_mid_req_regs: got %h/%h/%h/%h expected all 0", cause, info, epc, target);
    end
    tick();
    rst_n = 1'b1;
    irq_en = 4'b1111;
    mie    = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_pend_clear: got stall %b expected 0", stall); end
    mie    = 1'b0;
    irq_en = 4'b0110;
    tick();
  endtask

  task automatic test_vectored();
    logic [31:0] exp_t;
`ifdef TRAP_VECTORED_EN
    exp_t = 32'h8000_001C;
`else
    exp_t = 32'h8000_0000;
`endif
    mtvec = 32'h8000_0001; mie = 1'b1; mtime_exc = 1'b1; pc = 32'h304;
    push(32'h8000_0007, 32'h0, 32'h304, exp_t);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL vec_timer_detect: got %b expected 1", stall); end
    tick();
    drive_idle();
    mie = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    // Synchronous exceptions always use the base, whatever the mode.
    inst_valid = 1'b1; inst_invalid = 1'b1; pc = 32'h308;
    push(32'd2, 32'h308, 32'h308, 32'h8000_0000);
    tick();
    drive_idle();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    mtvec = MTVEC_D;
  endtask

  task automatic test_count_saturate();
    logic [CW-1:0] exp_c;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== '0) begin errors++; $display("FAIL cnt_reset: got %0d expected 0", count); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst_valid = 1'b1; inst_invalid = 1'b1; pc = 32'h400 + 32'(4 * i);
      push(32'd2, pc, pc, MTVEC_D);
      tick();
      drive_idle();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_c = (i >= 2) ? 2'd3 : CW'(i + 1);
      #1;
      checks++;
      if (count !== exp_c) begin errors++; $display("FAIL cnt_ack[%0d]: got %0d expected %0d", i, count, exp_c); end
      mret = 1'b1;
      tick();
      mret = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    irq    = '0;
    irq_en = '0;
    mie    = 1'b0;
    mtvec  = MTVEC_D;
    pc     = 32'h200;
    rst_n  = 1'b1;
    #2;
    rst_n  = 1'b0;
    test_reset();
    test_instr_misalign();
    test_sync_table();
    test_irq();
    test_double_fault_reset();
    test_vectored();
    test_count_saturate();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
